// File: rtl/aes_core_arbiter_if.sv
// Requester and response channels between two AES clients and the shared-core arbiter.
interface aes_core_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_text;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_text;
    logic [127:0] req1_key;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_cipher;
    logic         resp_id;

    modport master (
        output req0_valid, req0_text, req0_key,
        output req1_valid, req1_text, req1_key,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_cipher, resp_id
    );

    modport slave (
        input  req0_valid, req0_text, req0_key,
        input  req1_valid, req1_text, req1_key,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_cipher, resp_id
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sequencer sharing one combinational AES-128 core between two requesters,
// holding the core operands for a multicycle settle window before capturing the cipher.
module aes_core_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    aes_core_arbiter_if.slave   bus,
    output logic [127:0]        core_plain_text,
    output logic [127:0]        core_key,
    input  logic [127:0]        core_cipher,
    output logic                busy,
    output logic [15:0]         done_count
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       core_text_q, core_text_d;
    logic [127:0]       core_key_q, core_key_d;
    logic [127:0]       resp_cipher_q, resp_cipher_d;
    logic               resp_id_q, resp_id_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;
    logic [15:0]        done_count_q, done_count_d;

    logic               grant0_s;
    logic               grant1_s;
    logic               accept_s;
    logic               winner_s;

    // Arbitration: on contention the requester that did not win last time goes first.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_q == ST_IDLE) && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_s = last_grant_q;
                grant1_s = !last_grant_q;
            end else begin
                grant0_s = bus.req0_valid;
                grant1_s = bus.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s = grant0_s | grant1_s;
    assign winner_s = grant1_s;

    // Sequencer next state: load operands, count down the settle window, hold the response.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        core_text_d   = core_text_q;
        core_key_d    = core_key_q;
        resp_cipher_d = resp_cipher_q;
        resp_id_d     = resp_id_q;
        resp_valid_d  = resp_valid_q;
        busy_d        = busy_q;
        done_count_d  = done_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_WAIT;
                    last_grant_d = winner_s;
                    resp_id_d    = winner_s;
                    cnt_d        = CNT_LOAD;
                    busy_d       = 1'b1;
                    if (winner_s) begin
                        core_text_d = bus.req1_text;
                        core_key_d  = bus.req1_key;
                    end else begin
                        core_text_d = bus.req0_text;
                        core_key_d  = bus.req0_key;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    resp_cipher_d = core_cipher;
                    resp_valid_d  = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State register; reset drops any in-flight operation without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= CNT_ZERO;
            core_text_q   <= 128'd0;
            core_key_q    <= 128'd0;
            resp_cipher_q <= 128'd0;
            resp_id_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            core_text_q   <= core_text_d;
            core_key_q    <= core_key_d;
            resp_cipher_q <= resp_cipher_d;
            resp_id_q     <= resp_id_d;
            resp_valid_q  <= resp_valid_d;
            busy_q        <= busy_d;
            done_count_q  <= done_count_d;
        end
    end

    assign bus.req0_ready   = grant0_s;
    assign bus.req1_ready   = grant1_s;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_cipher  = resp_cipher_q;
    assign bus.resp_id      = resp_id_q;
    assign core_plain_text  = core_text_q;
    assign core_key         = core_key_q;
    assign busy             = busy_q;
    assign done_count       = done_count_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural AES-128 core on each instance.
module tb_aes_core_arbiter;

    localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C0  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int S0 = 4;
    localparam int S1 = 1;

    typedef struct {
        logic         id;
        logic [127:0] cipher;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [127:0] core_pt0, core_key0, core_ct0;
    logic [127:0] core_pt1, core_key1, core_ct1;
    logic         busy, busy1;
    logic [15:0]  done_count, done_count1;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           acc1_last = 0;
    logic         prev_rv = 1'b0;
    logic         prev_rv1 = 1'b0;
    logic [127:0] exp_c0 = C0;
    logic [127:0] exp_c1 = C1;
    exp_t         sb[$];
    logic         got_ids[$];
    int           acc1_hist[$];

    aes_core_arbiter_if bus ();
    aes_core_arbiter_if bus1 ();

    aes_core_arbiter #(.SETTLE_CYCLES(S0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_plain_text(core_pt0), .core_key(core_key0), .core_cipher(core_ct0),
        .busy(busy), .done_count(done_count)
    );

    aes_core_arbiter #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .core_plain_text(core_pt1), .core_key(core_key1), .core_cipher(core_ct1),
        .busy(busy1), .done_count(done_count1)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c + rr] = s[4*((c + rr) % 4) + rr];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                    s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    assign core_ct0 = aes128(core_pt0, core_key0);
    assign core_ct1 = aes128(core_pt1, core_key1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 128'(busy), 128'd0);
    endtask

    // Scoreboard for the SETTLE_CYCLES=4 instance: push on accept, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{1'b0, exp_c0});
                acc_cyc <= cyc;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{1'b1, exp_c1});
                acc_cyc <= cyc;
            end
            if (busy) chk("ready_while_busy", 128'({bus.req0_ready, bus.req1_ready}), 128'd0);
            else      chk("single_grant", 128'(bus.req0_ready & bus.req1_ready), 128'd0);
            if (bus.resp_valid && !prev_rv) chk("latency", 128'(cyc - acc_cyc), 128'(S0 + 1));
            if (bus.resp_valid && bus.resp_ready) begin
                got_ids.push_back(bus.resp_id);
                chk("resp_outstanding", 128'(sb.size()), 128'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", 128'(bus.resp_id), 128'(e.id));
                    chk("resp_cipher", bus.resp_cipher, e.cipher);
                end
            end
        end
        prev_rv <= bus.resp_valid;
    end

    // Monitor for the SETTLE_CYCLES=1 instance, which only ever carries the first vector on req0.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.req0_valid && bus1.req0_ready) begin
                acc1_hist.push_back(cyc);
                acc1_last <= cyc;
            end
            if (bus1.resp_valid && !prev_rv1) chk("s1_latency", 128'(cyc - acc1_last), 128'(S1 + 1));
            if (bus1.resp_valid && bus1.resp_ready) begin
                chk("s1_cipher", bus1.resp_cipher, C0);
                chk("s1_id", 128'(bus1.resp_id), 128'd0);
            end
        end
        prev_rv1 <= bus1.resp_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_text = PT0; bus.req0_key = K0;
        bus.req1_valid = 1'b0; bus.req1_text = PT1; bus.req1_key = K1;
        bus.resp_ready = 1'b1;
        bus1.req0_valid = 1'b0; bus1.req0_text = PT0; bus1.req0_key = K0;
        bus1.req1_valid = 1'b0; bus1.req1_text = PT1; bus1.req1_key = K1;
        bus1.resp_ready = 1'b1;

        // Reset state, with a request presented while rst is high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 128'(bus.req0_ready), 128'd0);
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done_count), 128'd0);
        chk("rst_core_pt", core_pt0, 128'd0);
        chk("rst_core_key", core_key0, 128'd0);
        chk("rst_cipher", bus.resp_cipher, 128'd0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        step();

        // Single request on requester 0.
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready", 128'(bus.req0_ready), 128'd1);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_core_pt", core_pt0, PT0);
        chk("t1_core_key", core_key0, K0);
        chk("t1_busy", 128'(busy), 128'd1);
        wait_idle("t1");
        chk("t1_done", 128'(done_count), 128'd1);
        step();

        // Contention from reset: grants alternate starting with requester 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        got_ids.delete();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        n = 0;
        while (got_ids.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2_progress", 128'(got_ids.size() >= 4), 128'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        wait_idle("t2");
        for (int k = 0; k < 4; k++) chk($sformatf("t2_order%0d", k), 128'(got_ids[k]), 128'(k % 2));
        chk("t2_done", 128'(done_count), 128'(got_ids.size()));
        step();

        // Response backpressure with both requesters pending.
        bus.req0_valid = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        bus.resp_ready = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_resp_valid", 128'(bus.resp_valid), 128'd1);
        step();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", 128'(bus.resp_valid), 128'd1);
            chk("t3_hold_cipher", bus.resp_cipher, C0);
            chk("t3_hold_id", 128'(bus.resp_id), 128'd0);
            chk("t3_hold_ready", 128'({bus.req0_ready, bus.req1_ready}), 128'd0);
        end
        base = got_ids.size();
        chk("t3_done_held", 128'(done_count), 128'(base));
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        wait_idle("t3");
        chk("t3_one_handshake", 128'(got_ids.size()), 128'(base + 1));
        chk("t3_done", 128'(done_count), 128'(base + 1));
        step();

        // Reset two cycles after an accept drops the operation.
        bus.req1_valid = 1'b1;
        step();
        bus.req1_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        step();
        @(negedge clk);
        chk("t4_rst_ready0", 128'(bus.req0_ready), 128'd0);
        chk("t4_resp_valid", 128'(bus.resp_valid), 128'd0);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_done", 128'(done_count), 128'd0);
        chk("t4_core_pt", core_pt0, 128'd0);
        chk("t4_core_key", core_key0, 128'd0);
        chk("t4_cipher", bus.resp_cipher, 128'd0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_no_resp", 128'(bus.resp_valid), 128'd0);
        end
        step();
        bus.req1_valid = 1'b1;
        step();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        wait_idle("t4");
        chk("t4_done_after", 128'(done_count), 128'd1);
        step();

        // Completion counter wrap from 0xFFFE.
        force dut.done_count_q = 16'hFFFE;
        step();
        release dut.done_count_q;
        @(negedge clk);
        chk("t6_preload", 128'(done_count), 128'hFFFE);
        for (int k = 0; k < 2; k++) begin
            step();
            bus.req0_valid = 1'b1;
            step();
            bus.req0_valid = 1'b0;
            @(negedge clk);
            wait_idle("t6");
            chk($sformatf("t6_done%0d", k), 128'(done_count), (k == 0) ? 128'hFFFF : 128'h0);
        end
        step();

        // SETTLE_CYCLES=1 instance with the request held continuously.
        bus1.req0_valid = 1'b1;
        n = 0;
        while (acc1_hist.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_progress", 128'(acc1_hist.size() >= 3), 128'd1);
        step();
        bus1.req0_valid = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_idle", 128'(busy1), 128'd0);
        chk("t5_gap0", 128'(acc1_hist[1] - acc1_hist[0]), 128'd3);
        chk("t5_gap1", 128'(acc1_hist[2] - acc1_hist[1]), 128'd3);
        chk("t5_done", 128'(done_count1), 128'(acc1_hist.size()));

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
